// File: rtl/axis_chk_pkg.sv
// rtl/axis_chk_pkg.sv - shared LFSR definitions for the AXIS checker
// Contents: LFSR width, tap positions, lfsr_step(), sync mode enum.
package axis_chk_pkg;

  localparam int LFSR_W = 64;

  // Fibonacci feedback taps of the traffic generator's 64-bit LFSR
  localparam int TAP_A = 63;
  localparam int TAP_B = 62;
  localparam int TAP_C = 60;
  localparam int TAP_D = 59;

  typedef enum logic {
    SYNC_RESET      = 1'b0,
    SYNC_FIRST_BEAT = 1'b1
  } sync_mode_e;

  // One generator step: shift left, feedback into bit 0
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D]};
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter with synchronous clear
// Ports:
//   clk_i  clock
//   clr_i  synchronous clear (active high)
//   inc_i  increment request
//   cnt_o  counter value, sticks at all-ones
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/axis_chk.sv
// rtl/axis_chk.sv - AXI-stream sink checking LFSR data and last framing
// Ports:
//   clk, s_rst            clock, synchronous active-high reset
//   en                    enables ready generation and pattern rotation
//   valid, last, data_in  incoming stream
//   ready                 registered backpressure output
//   locked                expected-data tracker aligned
//   pkt_cnt               beats carrying last (saturating)
//   data_err_cnt          beats with data mismatch (saturating)
//   last_err_cnt          beats with framing mismatch (saturating)
//   err                   sticky error flag
module axis_chk
  import axis_chk_pkg::*;
#(
  parameter int          N         = 16,
  parameter int          DATAW     = 64,
  parameter logic [63:0] SEED      = 64'hFEDCBA9876543210,
  parameter int          SYNC_MODE = 0,
  parameter logic [7:0]  READY_PAT = 8'hFF,
  parameter int          CNTW      = 16
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             en,
  input  logic             valid,
  input  logic             last,
  input  logic [DATAW-1:0] data_in,
  output logic             ready,
  output logic             locked,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic [CNTW-1:0]  data_err_cnt,
  output logic [CNTW-1:0]  last_err_cnt,
  output logic             err
);

  localparam int              IDXW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam sync_mode_e      MODE     = (SYNC_MODE != 0) ? SYNC_FIRST_BEAT : SYNC_RESET;

  if (N < 1) begin : g_bad_n
    $error("axis_chk: N must be at least 1");
  end
  if (DATAW < 1 || DATAW > LFSR_W) begin : g_bad_dataw
    $error("axis_chk: DATAW must be within 1..64");
  end
  if (SEED == 64'd0) begin : g_bad_seed
    $error("axis_chk: SEED must be nonzero");
  end
  if (MODE == SYNC_FIRST_BEAT && DATAW != LFSR_W) begin : g_bad_sync
    $error("axis_chk: self-sync needs the full 64-bit state on data_in");
  end

  logic [7:0]        pat_q, pat_d;
  logic              ready_q, ready_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic              locked_q, locked_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              err_q, err_d;

  logic              beat;
  logic              idx_at_end;
  logic              data_mis;
  logic              last_mis;
  logic              pkt_inc;
  logic [LFSR_W-1:0] data_ext;

  assign beat       = valid && ready_q;
  assign idx_at_end = (idx_q == LAST_IDX);
  assign data_ext   = LFSR_W'(data_in);
  assign data_mis   = beat && locked_q && (data_in != exp_q[DATAW-1:0]);
  assign last_mis   = beat && (last != idx_at_end);
  assign pkt_inc    = beat && last;

  always_comb begin
    pat_d    = pat_q;
    ready_d  = 1'b0;
    if (en) begin
      ready_d = pat_q[0];
      pat_d   = {pat_q[0], pat_q[7:1]};
    end

    // The tracker follows the generator cycle by cycle, not beat by beat.
    exp_d    = lfsr_step(exp_q);
    locked_d = locked_q;
    if (MODE == SYNC_FIRST_BEAT && !locked_q && beat) begin
      exp_d    = lfsr_step(data_ext);
      locked_d = 1'b1;
    end

    // An early last restarts the packet so later packets realign.
    idx_d = idx_q;
    if (beat) begin
      idx_d = (last || idx_at_end) ? '0 : idx_q + IDXW'(1);
    end

    err_d = err_q | data_mis | last_mis;
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      pat_q    <= READY_PAT;
      ready_q  <= 1'b0;
      exp_q    <= SEED;
      locked_q <= (MODE == SYNC_RESET);
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      ready_q  <= ready_d;
      exp_q    <= exp_d;
      locked_q <= locked_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  sat_cnt #(.W(CNTW)) u_pkt_cnt (
    .clk_i (clk),
    .clr_i (s_rst),
    .inc_i (pkt_inc),
    .cnt_o (pkt_cnt)
  );

  sat_cnt #(.W(CNTW)) u_data_err_cnt (
    .clk_i (clk),
    .clr_i (s_rst),
    .inc_i (data_mis),
    .cnt_o (data_err_cnt)
  );

  sat_cnt #(.W(CNTW)) u_last_err_cnt (
    .clk_i (clk),
    .clr_i (s_rst),
    .inc_i (last_mis),
    .cnt_o (last_err_cnt)
  );

  assign ready  = ready_q;
  assign locked = locked_q;
  assign err    = err_q;

endmodule
